// File: rtl/stream_demux_n.sv
// rtl/stream_demux_n.sv - registered 1-to-N valid/ready stream demultiplexer
// Routes accepted words by explicit select or round-robin pointer into per-channel one-entry registers.
module stream_demux_n #(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [W-1:0]   D,
  input  logic           D_VALID,
  output logic           D_READY,
  input  logic [SW-1:0]  SEL,
  input  logic           MODE,
  output logic [N*W-1:0] Y,
  output logic [N-1:0]   Y_VALID,
  input  logic [N-1:0]   Y_READY,
  output logic [SW-1:0]  RR_PTR,
  output logic [7:0]     DROP_CNT,
  output logic           ERR
);

  localparam int            NP    = 1 << SW;
  localparam logic [SW:0]   N_EXT = (SW+1)'(N);
  localparam logic [SW-1:0] LAST  = SW'(N-1);

  logic [W-1:0]  y_q [N];
  logic [W-1:0]  y_d [N];
  logic [N-1:0]  yv_q, yv_d;
  logic [SW-1:0] rr_q, rr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [SW-1:0] tgt;
  logic          tgt_ok;
  logic [NP-1:0] free_ext;
  logic          xfer;
  logic          drop;

  // Free vector is widened to the full select range so an out-of-range index reads 0.
  always_comb begin
    tgt      = MODE ? rr_q : SEL;
    tgt_ok   = {1'b0, tgt} < N_EXT;
    free_ext = '0;
    for (int i = 0; i < N; i++) begin
      free_ext[i] = !yv_q[i] || Y_READY[i];
    end
    D_READY = tgt_ok ? free_ext[tgt] : 1'b1;
    xfer    = D_VALID && D_READY;
    drop    = xfer && !tgt_ok;
  end

  always_comb begin
    yv_d = yv_q;
    for (int i = 0; i < N; i++) begin
      y_d[i] = y_q[i];
      if (yv_q[i] && Y_READY[i]) begin
        yv_d[i] = 1'b0;
      end
      // A load wins over a drain so a channel can sustain one word per cycle.
      if (xfer && tgt_ok && (tgt == SW'(i))) begin
        yv_d[i] = 1'b1;
        y_d[i]  = D;
      end
    end

    rr_d = rr_q;
    if (xfer && MODE) begin
      rr_d = (rr_q == LAST) ? '0 : rr_q + 1'b1;
    end

    cnt_d = cnt_q;
    if (drop && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end

    err_d = drop;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        y_q[i] <= '0;
      end
      yv_q  <= '0;
      rr_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        y_q[i] <= y_d[i];
      end
      yv_q  <= yv_d;
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    Y = '0;
    for (int i = 0; i < N; i++) begin
      Y[i*W +: W] = y_q[i];
    end
  end

  assign Y_VALID  = yv_q;
  assign RR_PTR   = rr_q;
  assign DROP_CNT = cnt_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// tb/tb_stream_demux_n.sv - self-checking bench for stream_demux_n
// Instance a is the default 8-channel build, instance b a 6-channel build with invalid selects.
module tb_stream_demux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_dv, a_mode, a_drdy, a_err;
  logic [7:0]  a_d, a_yv, a_yr, a_cnt;
  logic [2:0]  a_sel, a_rr;
  logic [63:0] a_y;

  logic        b_rst, b_dv, b_mode, b_drdy, b_err;
  logic [7:0]  b_d, b_cnt;
  logic [5:0]  b_yv, b_yr;
  logic [2:0]  b_sel, b_rr;
  logic [47:0] b_y;

  stream_demux_n #(.N(8), .W(8)) u_a (
    .CLK(clk), .RST(a_rst), .D(a_d), .D_VALID(a_dv), .D_READY(a_drdy),
    .SEL(a_sel), .MODE(a_mode), .Y(a_y), .Y_VALID(a_yv), .Y_READY(a_yr),
    .RR_PTR(a_rr), .DROP_CNT(a_cnt), .ERR(a_err)
  );

  stream_demux_n #(.N(6), .W(8)) u_b (
    .CLK(clk), .RST(b_rst), .D(b_d), .D_VALID(b_dv), .D_READY(b_drdy),
    .SEL(b_sel), .MODE(b_mode), .Y(b_y), .Y_VALID(b_yv), .Y_READY(b_yr),
    .RR_PTR(b_rr), .DROP_CNT(b_cnt), .ERR(b_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         mode;
    logic [2:0] sel;
    logic [7:0] d;
    logic [7:0] exp_yv;
    int         exp_ch;
    logic [2:0] exp_rr;
  } vec_t;

  vec_t tbl [18];

  logic        m_v [6];
  logic [7:0]  m_y [6];
  int          m_rr, m_cnt;
  bit          m_err;

  int          tgt;
  bit          ok, rdy, xf;
  logic [5:0]  ev;
  logic [47:0] ey;

  initial begin
    a_rst = 1'b1; a_dv = 1'b0; a_mode = 1'b0; a_d = '0; a_sel = '0; a_yr = '0;
    b_rst = 1'b1; b_dv = 1'b0; b_mode = 1'b0; b_d = '0; b_sel = '0; b_yr = '0;
    tick();
    tick();
    a_rst = 1'b0;
    b_rst = 1'b0;

    for (int n = 0; n < 8; n++) begin
      tbl[n].mode   = 1'b0;
      tbl[n].sel    = 3'(n);
      tbl[n].d      = 8'hA0 + 8'(n);
      tbl[n].exp_yv = 8'(1 << n);
      tbl[n].exp_ch = n;
      tbl[n].exp_rr = 3'd0;
    end
    for (int j = 0; j < 10; j++) begin
      tbl[8+j].mode   = 1'b1;
      tbl[8+j].sel    = 3'd0;
      tbl[8+j].d      = 8'h30 + 8'(j);
      tbl[8+j].exp_yv = 8'(1 << (j % 8));
      tbl[8+j].exp_ch = j % 8;
      tbl[8+j].exp_rr = 3'((j + 1) % 8);
    end

    chk("rst_yvalid", a_yv, 0);
    chk("rst_y", a_y, 0);
    chk("rst_rrptr", a_rr, 0);
    chk("rst_dropcnt", a_cnt, 0);
    chk("rst_err", a_err, 0);
    chk("rst_dready", a_drdy, 1);

    // Explicit select sweep followed by ten round-robin words
    a_yr = 8'hFF;
    a_dv = 1'b1;
    for (int r = 0; r < 18; r++) begin
      a_mode = tbl[r].mode;
      a_sel  = tbl[r].sel;
      a_d    = tbl[r].d;
      #1;
      chk($sformatf("tbl%0d_dready", r), a_drdy, 1);
      tick();
      chk($sformatf("tbl%0d_yvalid", r), a_yv, tbl[r].exp_yv);
      chk($sformatf("tbl%0d_y", r), a_y[tbl[r].exp_ch*8 +: 8], tbl[r].d);
      chk($sformatf("tbl%0d_rrptr", r), a_rr, tbl[r].exp_rr);
    end
    a_dv = 1'b0;

    // Backpressure on channel 3
    a_mode = 1'b0; a_sel = 3'd3; a_yr = 8'hF7; a_dv = 1'b1; a_d = 8'h11;
    #1;
    chk("bp_dready_first", a_drdy, 1);
    tick();
    chk("bp_y3_first", a_y[31:24], 8'h11);
    chk("bp_yv3_first", a_yv[3], 1);
    a_d = 8'h22;
    #1;
    chk("bp_dready_stall", a_drdy, 0);
    tick();
    chk("bp_y3_held", a_y[31:24], 8'h11);
    a_yr = 8'hFF;
    #1;
    chk("bp_dready_release", a_drdy, 1);
    tick();
    chk("bp_y3_second", a_y[31:24], 8'h22);
    chk("bp_yv3_second", a_yv[3], 1);
    a_dv = 1'b0;
    tick();
    chk("bp_yv_drained", a_yv, 0);

    // Mode switch keeps the round-robin pointer
    a_mode = 1'b1; a_dv = 1'b1; a_d = 8'h40;
    for (int k = 0; k < 16 && a_rr != 3'd4; k++) tick();
    chk("ms_rr_reached4", a_rr, 4);
    a_mode = 1'b0; a_sel = 3'd0; a_d = 8'h5A;
    tick();
    chk("ms_yv0", a_yv[0], 1);
    chk("ms_y0", a_y[7:0], 8'h5A);
    chk("ms_rr_kept", a_rr, 4);
    a_mode = 1'b1; a_d = 8'h6B;
    tick();
    chk("ms_yv4", a_yv[4], 1);
    chk("ms_y4", a_y[39:32], 8'h6B);
    chk("ms_rr_adv", a_rr, 5);
    a_dv = 1'b0;
    tick();

    // Reset discards held words
    a_mode = 1'b0; a_yr = 8'h00; a_dv = 1'b1;
    a_sel = 3'd1; a_d = 8'hC1;
    tick();
    a_sel = 3'd5; a_d = 8'hC5;
    tick();
    a_dv = 1'b0;
    chk("rs_yv_loaded", a_yv, 8'h22);
    chk("rs_rr_before", a_rr, 5);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    chk("rs_yvalid", a_yv, 0);
    chk("rs_y", a_y, 0);
    chk("rs_rrptr", a_rr, 0);
    chk("rs_dropcnt", a_cnt, 0);

    // Invalid selects on the 6-channel build
    b_yr = 6'h3F; b_mode = 1'b0; b_dv = 1'b1; b_sel = 3'd6; b_d = 8'hEE;
    #1;
    chk("inv_dready_sel6", b_drdy, 1);
    tick();
    chk("inv_yv_sel6", b_yv, 0);
    chk("inv_err_sel6", b_err, 1);
    chk("inv_cnt_1", b_cnt, 1);
    b_sel = 3'd7;
    #1;
    chk("inv_dready_sel7", b_drdy, 1);
    tick();
    chk("inv_yv_sel7", b_yv, 0);
    chk("inv_err_sel7", b_err, 1);
    chk("inv_cnt_2", b_cnt, 2);
    b_dv = 1'b0;
    tick();
    chk("inv_err_clear", b_err, 0);
    chk("inv_cnt_hold", b_cnt, 2);
    b_dv = 1'b1; b_sel = 3'd5; b_d = 8'h55;
    tick();
    chk("inv_top_yv", b_yv, 6'h20);
    chk("inv_top_y", b_y[47:40], 8'h55);
    chk("inv_top_err", b_err, 0);
    b_sel = 3'd7;
    repeat (300) tick();
    b_dv = 1'b0;
    tick();
    chk("inv_cnt_sat", b_cnt, 255);

    // Random traffic on the 6-channel build against a rule-level model
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_v[i] = 1'b0;
      m_y[i] = 8'h00;
    end
    m_rr = 0; m_cnt = 0; m_err = 1'b0;
    repeat (1500) begin
      if ($urandom_range(0, 9) == 0) b_mode = !b_mode;
      b_sel = 3'($urandom_range(0, 7));
      b_dv  = ($urandom_range(0, 3) != 0);
      b_yr  = 6'($urandom);
      b_d   = 8'($urandom);
      #1;
      tgt = b_mode ? m_rr : int'(b_sel);
      ok  = (tgt < 6);
      rdy = ok ? (!m_v[tgt] || b_yr[tgt]) : 1'b1;
      chk("rnd_dready", b_drdy, rdy);
      xf = b_dv && rdy;
      for (int i = 0; i < 6; i++) begin
        if (m_v[i] && b_yr[i]) m_v[i] = 1'b0;
      end
      if (xf && ok) begin
        m_v[tgt] = 1'b1;
        m_y[tgt] = b_d;
      end
      m_err = xf && !ok;
      if (m_err && m_cnt < 255) m_cnt++;
      if (xf && b_mode) m_rr = (m_rr + 1) % 6;
      tick();
      for (int i = 0; i < 6; i++) begin
        ev[i] = m_v[i];
        ey[i*8 +: 8] = m_y[i];
      end
      chk("rnd_yvalid", b_yv, ev);
      chk("rnd_y", b_y, ey);
      chk("rnd_rrptr", b_rr, m_rr);
      chk("rnd_dropcnt", b_cnt, m_cnt);
      chk("rnd_err", b_err, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
